// File: rtl/uart_tx_core.sv
// UART transmitter: TX FIFO, runtime baud divisor, 1/2 stop bits, frames sent LSB first.
// Optional parity bit generation is built only when UART_TX_PARITY_EN is defined.
module uart_tx_core #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    input  logic [DIV_W-1:0]  cfg_baud_div,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    input  logic              ovf_clr,
    output logic              txd,
    output logic              busy,
    output logic              tx_done,
    output logic              ovf
);

    localparam int unsigned BW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,S_PARITY = 3'd4
`endif
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       level_n;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_q;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] sh;
    logic              stop2_q;
    logic              stop_cnt;
    logic              tick;
    logic              txd_n;
    logic              done_n;

`ifdef UART_TX_PARITY_EN
    logic              par_en_q;
    logic              par_bit_q;
`else
    logic              unused_parity;
    assign unused_parity = ^cfg_parity;
`endif

    // FIFO control: a pop in the same cycle frees the slot for a write when full
    always_comb begin
        push    = wr_en && (!full || pop);
        level_n = level;
        if (push && !pop) begin
            level_n = level + (AW+1)'(1);
        end else if (pop && !push) begin
            level_n = level - (AW+1)'(1);
        end
    end

    assign head = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            level <= level_n;
            full  <= (level_n == (AW+1)'(FIFO_DEPTH));
            empty <= (level_n == '0);
            // a dropped write wins over a simultaneous clear
            if (wr_en && !push) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state, pop request and next line level
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        txd_n   = 1'b1;
        done_n  = 1'b0;
        tick    = (cnt == div_q);
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                txd_n = 1'b0;
                if (tick) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                txd_n = sh[0];
                if (tick && (bit_cnt == BW'(DATA_W - 1))) begin
`ifdef UART_TX_PARITY_EN
                    state_n = par_en_q ? S_PARITY : S_STOP;
`else
                    state_n = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                txd_n = par_bit_q;
                if (tick) begin
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                txd_n = 1'b1;
                if (tick && (stop_cnt || !stop2_q)) begin
                    done_n = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Frame datapath: config is latched with the popped word so mid-frame changes are ignored
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            div_q    <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            stop2_q  <= 1'b0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else if (pop) begin
            cnt      <= '0;
            div_q    <= cfg_baud_div;
            bit_cnt  <= '0;
            sh       <= head;
            stop2_q  <= cfg_stop2;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= ^cfg_parity;
            par_bit_q <= (cfg_parity == 2'b10) ? ^head : ~^head;
`endif
        end else if (state != S_IDLE) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
            if (tick && (state == S_DATA)) begin
                sh      <= {1'b0, sh[DATA_W-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (tick && (state == S_STOP)) begin
                stop_cnt <= 1'b1;
            end
        end
    end

    // Line outputs are registered one cycle behind the state
    always_ff @(posedge clk) begin
        if (!rst) begin
            txd     <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            txd     <= txd_n;
            busy    <= (state != S_IDLE);
            tx_done <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: frame shape, latency, back-to-back, FIFO overflow, reset, config latch.
module tb_uart_tx_core;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned DIV_W      = 16;
    localparam int unsigned AW         = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              full;
    logic              empty;
    logic [AW:0]       level;
    logic [DIV_W-1:0]  cfg_baud_div = 16'd3;
    logic [1:0]        cfg_parity = 2'b00;
    logic              cfg_stop2 = 1'b0;
    logic              ovf_clr = 1'b0;
    logic              txd;
    logic              busy;
    logic              tx_done;
    logic              ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    uart_tx_core #(
        .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DIV_W(DIV_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .empty(empty),
        .level(level),
        .cfg_baud_div(cfg_baud_div),
        .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2),
        .ovf_clr(ovf_clr),
        .txd(txd),
        .busy(busy),
        .tx_done(tx_done),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one write strobe; returns at the negedge after the write edge
    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // pmode: 0 none, 1 odd, 2 even; checks first and last clock of every bit
    task automatic check_frame(input string tag, input logic [7:0] d, input int div,
                               input int pmode, input bit stop2, input int max_wait);
        logic exp_bits [13];
        int   nb;
        int   w;
        int   d0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1+i] = d[i];
        nb = 9;
        if (pmode == 2) begin exp_bits[nb] = ^d;  nb++; end
        if (pmode == 1) begin exp_bits[nb] = ~^d; nb++; end
        exp_bits[nb] = 1'b1; nb++;
        if (stop2) begin exp_bits[nb] = 1'b1; nb++; end
        w = 0;
        while (txd !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        d0 = done_cnt;
        for (int i = 0; i < nb; i++) begin
            check($sformatf("%s bit%0d first", tag, i), 32'(txd), 32'(exp_bits[i]));
            check($sformatf("%s busy%0d first", tag, i), 32'(busy), 32'd1);
            repeat (div) @(negedge clk);
            check($sformatf("%s bit%0d last", tag, i), 32'(txd), 32'(exp_bits[i]));
            check($sformatf("%s busy%0d last", tag, i), 32'(busy), 32'd1);
            @(negedge clk);
        end
        check($sformatf("%s tx_done count", tag), 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        repeat (3) @(negedge clk);
        check("rst txd", 32'(txd), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst level", 32'(level), 32'd0);
        check("rst empty", 32'(empty), 32'd1);
        check("rst full", 32'(full), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        check("rst tx_done", 32'(tx_done), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: 0xA5, div 3, no parity, one stop; latency write->start is two edges
        push(8'hA5);
        check("t1 level after write", 32'(level), 32'd1);
        check("t1 empty after write", 32'(empty), 32'd0);
        check("t1 txd N", 32'(txd), 32'd1);
        @(negedge clk);
        check("t1 txd N+1", 32'(txd), 32'd1);
        check("t1 busy N+1", 32'(busy), 32'd0);
        check("t1 level N+1", 32'(level), 32'd0);
        @(negedge clk);
        check("t1 busy N+2", 32'(busy), 32'd1);
        check_frame("t1", 8'hA5, 3, 0, 1'b0, 0);
        check("t1 busy after", 32'(busy), 32'd0);
        check("t1 txd idle", 32'(txd), 32'd1);

        // 2: parity modes and two stop bits
`ifdef UART_TX_PARITY_EN
        cfg_parity = 2'b10;
        push(8'h07);
        check_frame("t2 even", 8'h07, 3, 2, 1'b0, 10);
        cfg_parity = 2'b01;
        push(8'h07);
        check_frame("t2 odd", 8'h07, 3, 1, 1'b0, 10);
        cfg_stop2 = 1'b1;
        push(8'h07);
        check_frame("t2 odd stop2", 8'h07, 3, 1, 1'b1, 10);
        cfg_stop2 = 1'b0;
        cfg_parity = 2'b11;
        push(8'h07);
        check_frame("t2 mode11 none", 8'h07, 3, 0, 1'b0, 10);
`else
        cfg_parity = 2'b01;
        push(8'h07);
        check_frame("t2 parity ignored", 8'h07, 3, 0, 1'b0, 10);
        cfg_stop2 = 1'b1;
        push(8'h07);
        check_frame("t2 stop2", 8'h07, 3, 0, 1'b1, 10);
`endif
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        check("t2 busy after", 32'(busy), 32'd0);

        // 3: back-to-back frames with no idle bit between them
        push(8'h55);
        push(8'hAA);
        check_frame("t3 first", 8'h55, 3, 0, 1'b0, 10);
        check_frame("t3 second", 8'hAA, 3, 0, 1'b0, 0);
        check("t3 busy after", 32'(busy), 32'd0);

        // 4: fill FIFO while sending, overflow, set-wins clear, then drain
        cfg_baud_div = 16'd7;
        push(8'h10);
        repeat (3) @(negedge clk);
        check("t4 busy sending", 32'(busy), 32'd1);
        check("t4 level sending", 32'(level), 32'd0);
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        check("t4 level full", 32'(level), 32'd16);
        check("t4 full", 32'(full), 32'd1);
        check("t4 ovf before", 32'(ovf), 32'd0);
        push(8'hEE);
        check("t4 level after 17th", 32'(level), 32'd16);
        check("t4 ovf set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        push(8'hEE);
        ovf_clr = 1'b0;
        check("t4 ovf set wins", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t4 ovf cleared", 32'(ovf), 32'd0);
        check("t4 level kept", 32'(level), 32'd16);
        w = 0;
        while (tx_done !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("t4 first frame done", 32'(tx_done), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check_frame($sformatf("t4 drain%0d", i), 8'(8'h20 + i), 7, 0, 1'b0, 0);
        end
        check("t4 busy drained", 32'(busy), 32'd0);
        check("t4 empty drained", 32'(empty), 32'd1);
        repeat (20) @(negedge clk);
        check("t4 no dropped frame txd", 32'(txd), 32'd1);
        check("t4 no dropped frame busy", 32'(busy), 32'd0);

        // 5: reset in the middle of data bit 3
        cfg_baud_div = 16'd3;
        push(8'h00);
        push(8'h33);
        w = 0;
        while (txd !== 1'b0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        repeat (17) @(negedge clk);
        check("t5 txd in bit3", 32'(txd), 32'd0);
        check("t5 level before rst", 32'(level), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("t5 txd after rst", 32'(txd), 32'd1);
        check("t5 busy after rst", 32'(busy), 32'd0);
        check("t5 level after rst", 32'(level), 32'd0);
        check("t5 empty after rst", 32'(empty), 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t5 stays idle", 32'(busy), 32'd0);
        push(8'h5A);
        check_frame("t5 clean", 8'h5A, 3, 0, 1'b0, 10);

        // 6: divisor change mid-frame affects only the next frame
        push(8'h96);
        push(8'h69);
        cfg_baud_div = 16'd7;
        check_frame("t6 div3", 8'h96, 3, 0, 1'b0, 10);
        check_frame("t6 div7", 8'h69, 7, 0, 1'b0, 0);
        check("t6 busy after", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
